// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
// Holds the default widths, the PC increment and the per-branch entry record.
package brq_pkg;

  localparam int BRQ_PC_W  = 32;
  localparam int BRQ_IDX_W = 8;
  localparam int PC_STEP   = 4;

  typedef struct packed {
    logic [BRQ_PC_W-1:0] pc;
    logic                pred_taken;
    logic [BRQ_PC_W-1:0] pred_target;
  } entry_t;

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer of predicted branches with a synchronous clear.
// A clear empties the queue in one edge while any same-cycle pop is still honoured.
module brq_fifo
  import brq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign rd_data    = mem[rd_ptr];
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);

  // NOTE: storage has no reset; an entry is only read after a push has
  // written it, so resetting the array would just cost flops and fan-out.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= rd_ptr_nxt;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr + PTR_W'(push);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in program order, resolves them against execute and
// drives predictor updates and mispredict flushes. Define BRQ_STATS_EN for counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BRQ_PC_W,
  parameter int IDX_W = BRQ_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_pred_taken,
  input  logic [PC_W-1:0]          push_pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  input  logic                     res_is_jump,
  input  logic                     ext_flush,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_addr,
  output logic                     upd_taken,
  output logic                     flush_valid,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
`ifdef BRQ_STATS_EN
  output logic [31:0]              stat_resolved,
  output logic [31:0]              stat_mispred,
`endif
  output logic                     err_underflow
);

  entry_t    wr_entry;
  entry_t    head;
  logic      full;
  logic      empty;
  logic      pop;
  logic      mispred;
  logic      kill;
  logic      push_acc;
  logic [PC_W-1:0] head_pc;
  logic [PC_W-1:0] head_target;

  assign head_pc     = PC_W'(head.pc);
  assign head_target = PC_W'(head.pred_target);

  assign push_ready = !full;
  assign pop        = res_valid && !empty;

  // A taken branch is only correct if both the direction and the target match.
  assign mispred = (res_taken != head.pred_taken) ||
                   (res_taken && (res_target != head_target));

  // Anything younger than a mispredicted branch or a trap is wrong-path.
  assign kill     = ext_flush || (pop && mispred);
  assign push_acc = push_valid && push_ready && !kill;

  always_comb begin
    wr_entry             = '0;
    wr_entry.pc          = BRQ_PC_W'(push_pc);
    wr_entry.pred_taken  = push_pred_taken;
    wr_entry.pred_target = BRQ_PC_W'(push_pred_target);
  end

  brq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_acc),
    .pop     (pop),
    .clear   (kill),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid     <= 1'b0;
      upd_addr      <= '0;
      upd_taken     <= 1'b0;
      flush_valid   <= 1'b0;
      redirect_pc   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid   <= pop && !res_is_jump;
      flush_valid <= pop && mispred && !ext_flush;
      if (pop && !res_is_jump) begin
        upd_addr  <= head_pc[IDX_W-1:0];
        upd_taken <= res_taken;
      end
      if (pop && mispred && !ext_flush) begin
        redirect_pc <= res_taken ? res_target : head_pc + PC_W'(PC_STEP);
      end
      if (res_valid && empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && (stat_resolved != '1)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (pop && mispred && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Holds every branch that fetch has predicted, in program order, until execute resolves it.
- On resolve, compares the actual outcome with the stored prediction and issues a one-cycle update to gshare_predictor (update, update_address, branch_taken).
- On a mispredict, raises a flush and redirect PC to fetch and drops all younger wrong-path entries.
- Sits between fetch/predict (upstream push) and execute (resolve), and feeds the predictor's update port.

Parameters:
DEPTH, 4, number of in-flight branch entries; power of 2, minimum 2
PC_W, 32, PC and target width
IDX_W, 8, width of update_addr; always PC[IDX_W-1:0]

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset
push_valid  in  1  fetch presents a predicted branch
push_ready  out  1  queue can accept; equals !full
push_pc  in  PC_W  branch instruction PC
push_pred_taken  in  1  predictor output at fetch
push_pred_target  in  PC_W  predicted target; ignored when not taken
res_valid  in  1  execute resolves the oldest branch
res_taken  in  1  actual direction
res_target  in  PC_W  actual target
res_is_jump  in  1  unconditional jal/jalr
ext_flush  in  1  external flush (trap); clears the queue
upd_valid  out  1  one-cycle pulse driving the predictor's update input
upd_addr  out  IDX_W  head PC[IDX_W-1:0]
upd_taken  out  1  actual direction for the predictor
flush_valid  out  1  one-cycle mispredict flush to fetch/decode
redirect_pc  out  PC_W  correct next PC when flush_valid=1
count  out  $clog2(DEPTH)+1  current occupancy
err_underflow  out  1  sticky; set when res_valid arrives while empty

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; push_ready=1.
  - upd_valid, upd_addr, upd_taken, flush_valid, redirect_pc, err_underflow all go to 0.
- Storage: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Push: accepted when push_valid && push_ready; entry is written at wr_ptr. A push while full is not accepted; push_ready is already 0.
- Resolve (res_valid=1, count>0): pops the head entry. The resolve outputs below are registered and appear 1 cycle after res_valid.
  - mispredict = (res_taken != pred_taken) OR (res_taken AND res_target != pred_target).
  - upd_valid=1, upd_addr=head PC[IDX_W-1:0], upd_taken=res_taken. This applies to conditional branches only; upd_valid stays 0 when res_is_jump=1.
  - On mispredict: flush_valid=1.
    - redirect_pc=res_target when res_taken=1, else head PC+4 (mod 2^PC_W).
    - The queue is cleared in the same edge: count=0, wr_ptr=rd_ptr.
- Simultaneous push and resolve:
  - Without mispredict: both happen; count is unchanged. A push when full is still refused, even during a pop.
  - With mispredict: the push is discarded as wrong-path.
- ext_flush=1: queue cleared; a same-cycle push is discarded.
  - A same-cycle resolve still produces its upd_valid pulse.
  - flush_valid is not asserted (ext_flush has its own redirect).
- res_valid while empty: no pop, no update, no flush; err_underflow is set and held until reset.
- Pulse width: upd_valid and flush_valid are exactly 1 cycle high per event.
- Back-to-back resolves each give their own pulse.
- Reset asserted mid-operation clears everything immediately; no pulse is emitted.

Optional Feature:
- BRQ_STATS_EN defined:
  - Adds outputs stat_resolved[31:0] and stat_mispred[31:0].
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
  - stat_resolved counts every valid pop; stat_mispred counts every mispredict.
- BRQ_STATS_EN undefined: the ports and counters do not exist.

Decomposition:
- Shared package brq_pkg:
  - Entry struct {pc, pred_taken, pred_target}.
  - PC_W and IDX_W defaults.
  - PC_STEP=4 constant.
- One natural sub-module, brq_fifo: circular buffer with pointers, count, and a clear input.
- Compare logic, output registers and stats stay in the top level.

Test Plan:
- Push pc=0x100, pred_taken=0; resolve res_taken=0 -> next cycle upd_valid=1, upd_addr=0x00, upd_taken=0, flush_valid=0, count=0.
- Push pc=0x1A4, pred_taken=0; resolve res_taken=1, target=0x200 -> upd_taken=1, upd_addr=0xA4, flush_valid=1, redirect_pc=0x200.
- Push 4 entries (DEPTH=4) -> push_ready=0; a 5th push is refused. Resolve the first correctly with a same-cycle push -> the push is still refused and count=3.
- Push pc=0x300 taken target 0x400, plus two younger entries; resolve taken target 0x404 -> flush_valid=1, redirect_pc=0x404, count=0.
- Resolve with res_is_jump=1, correct prediction -> upd_valid stays 0. Then res_valid on an empty queue -> err_underflow=1 and held until reset.
- Assert rst low mid-burst with count=3 -> count=0, push_ready=1, no pulses. With BRQ_STATS_EN defined, stats read 0 afterwards.
